// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: prioritized latch enable/flush sequencing with DWAIT watchdog, sticky halt and perf counters
module pipeline_ctrl #(
  parameter int DWAIT_MAX = 64,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       id_rsel1,
  input  logic [4:0]       id_rsel2,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_writeReg,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             ihit,
  input  logic             dmem_req,
  input  logic             dhit,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);
  typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;
  state_t st, nxt;
  logic lu, live, frz;
  logic [7:0] act;
  logic [15:0] wait_cnt;
  assign lu = ex_memread && ex_writeReg != 5'd0 &&
              ((id_use_rs && id_rsel1 == ex_writeReg) || (id_use_rt && id_rsel2 == ex_writeReg));
  // act = {pc, ifid, idex, exmem, memwb enables, ifid/idex/exmem flushes}
  always_comb begin
    live = st == RUN || (st == DWAIT && dhit);
    frz = st == RUN && dmem_req && !dhit;
    act = !live || halt_wb || frz ? 8'b00000_000 :
          branch_taken ? 8'b11111_110 :
          lu ? 8'b00111_010 :
          jump ? 8'b11111_100 :
          !ihit ? 8'b01111_100 : 8'b11111_000;
    if (RST) act = 8'b00000_111;
    nxt = st == HALT || (live && halt_wb) ? HALT :
          frz || (st == DWAIT && !dhit) ? DWAIT : RUN;
  end
  assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush} = act;
  assign halted = st == HALT && !RST;
  always_ff @(posedge CLK) begin
    if (RST) begin
      st <= RUN;
      wait_cnt <= '0;
      mem_timeout <= 1'b0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      st <= nxt;
      wait_cnt <= st == DWAIT ? wait_cnt + 16'(wait_cnt != '1) : '0;
      mem_timeout <= mem_timeout || (st == DWAIT && wait_cnt == 16'(DWAIT_MAX));
      stall_cycles <= stall_cycles + CNT_W'(st != HALT && !pc_en && stall_cycles != '1);
      flush_events <= flush_events + CNT_W'((|act[2:0]) && flush_events != '1);
    end
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scoreboard bench for pipeline_ctrl against a rule-list reference model
module tb_pipeline_ctrl;
  localparam int DM = 3, CW = 4, CMAX = (1 << CW) - 1;
  logic CLK = 0, RST = 1;
  logic [4:0] id_rsel1 = 0, id_rsel2 = 0, ex_writeReg = 0;
  logic id_use_rs = 0, id_use_rt = 0, ex_memread = 0, branch_taken = 0, jump = 0;
  logic ihit = 1, dmem_req = 0, dhit = 1, halt_wb = 0;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush;
  logic halted, mem_timeout;
  logic [CW-1:0] stall_cycles, flush_events;
  pipeline_ctrl #(.DWAIT_MAX(DM), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .id_rsel1(id_rsel1), .id_rsel2(id_rsel2),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_memread(ex_memread),
    .ex_writeReg(ex_writeReg), .branch_taken(branch_taken), .jump(jump), .ihit(ihit),
    .dmem_req(dmem_req), .dhit(dhit), .halt_wb(halt_wb), .pc_en(pc_en), .ifid_en(ifid_en),
    .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .halted(halted),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );
  always #5 CLK = ~CLK;
  typedef struct {logic [9:0] ctl; int sc; int fe; string tag;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int mode = 0, dlen = 0, sc = 0, fe = 0;
  bit tmo = 0;
  // mode: 0 running, 1 waiting on data memory, 2 halted
  task automatic model(string tag);
    logic [7:0] a;
    bit lu;
    exp_t e;
    lu = ex_memread && ex_writeReg != 0 &&
         ((id_use_rs && id_rsel1 == ex_writeReg) || (id_use_rt && id_rsel2 == ex_writeReg));
    e.tag = tag; e.sc = sc; e.fe = fe;
    if (RST) begin
      e.ctl = {8'b00000111, 1'b0, tmo};
      q.push_back(e);
      mode = 0; dlen = 0; tmo = 0; sc = 0; fe = 0;
      return;
    end
    if (mode == 2 || (mode == 1 && !dhit) || halt_wb || (mode == 0 && dmem_req && !dhit)) a = 8'b00000000;
    else if (branch_taken) a = 8'b11111110;
    else if (lu) a = 8'b00111010;
    else if (jump) a = 8'b11111100;
    else if (!ihit) a = 8'b01111100;
    else a = 8'b11111000;
    e.ctl = {a, mode == 2, tmo};
    q.push_back(e);
    if (mode != 2 && !a[7]) sc = sc < CMAX ? sc + 1 : CMAX;
    if (|a[2:0]) fe = fe < CMAX ? fe + 1 : CMAX;
    if (mode == 1) begin
      dlen++;
      if (dlen > DM) tmo = 1;
    end
    if (mode == 2 || (mode == 1 && !dhit)) ;
    else if (halt_wb) mode = 2;
    else if (mode == 0 && dmem_req && !dhit) begin mode = 1; dlen = 0; end
    else mode = 0;
  endtask
  task automatic step(string tag);
    model(tag);
    @(posedge CLK); #1;
  endtask
  task automatic idle();
    RST = 0; id_rsel1 = 0; id_rsel2 = 0; ex_writeReg = 0; id_use_rs = 0; id_use_rt = 0;
    ex_memread = 0; branch_taken = 0; jump = 0; ihit = 1; dmem_req = 0; dhit = 1; halt_wb = 0;
  endtask
  task automatic rnd(bit allow_rst);
    RST = allow_rst && $urandom_range(0, 40) == 0;
    id_rsel1 = 5'($urandom_range(0, 3)); id_rsel2 = 5'($urandom_range(0, 3));
    ex_writeReg = 5'($urandom_range(0, 3));
    id_use_rs = 1'($urandom); id_use_rt = 1'($urandom); ex_memread = 1'($urandom);
    branch_taken = $urandom_range(0, 5) == 0; jump = $urandom_range(0, 4) == 0;
    ihit = $urandom_range(0, 3) != 0; dmem_req = $urandom_range(0, 2) == 0;
    dhit = 1'($urandom); halt_wb = $urandom_range(0, 29) == 0;
  endtask
  always @(negedge CLK) if (q.size() != 0) begin
    exp_t e;
    e = q.pop_front();
    checks += 3;
    if ({pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush,
         halted, mem_timeout} !== e.ctl) begin
      errors++;
      $display("FAIL %s ctl got %b expected %b (pc,ifid,idex,exmem,memwb,fi,fd,fe,halt,tmo)", e.tag,
               {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush,
                halted, mem_timeout}, e.ctl);
    end
    if ($isunknown(stall_cycles) || int'(stall_cycles) != e.sc) begin
      errors++;
      $display("FAIL %s stall_cycles got %0d expected %0d", e.tag, stall_cycles, e.sc);
    end
    if ($isunknown(flush_events) || int'(flush_events) != e.fe) begin
      errors++;
      $display("FAIL %s flush_events got %0d expected %0d", e.tag, flush_events, e.fe);
    end
  end
  initial begin
    idle(); RST = 1;
    @(posedge CLK); #1;
    step("reset"); step("reset");
    idle(); step("idle"); step("idle");
    ex_memread = 1; ex_writeReg = 8; id_rsel2 = 8; id_use_rt = 1; step("load_use");
    idle(); step("after_lu");
    ex_memread = 1; ex_writeReg = 0; id_rsel2 = 0; id_use_rt = 1; step("lu_r0");
    idle(); ex_memread = 1; ex_writeReg = 8; id_rsel1 = 8; id_use_rs = 1;
    branch_taken = 1; ihit = 0; step("branch_lu_miss");
    idle(); step("idle");
    dmem_req = 1; dhit = 0;
    for (int i = 0; i < 5; i++) step("dwait");
    dhit = 1; step("dwait_hit");
    idle(); step("post_dwait"); step("post_dwait");
    halt_wb = 1; step("halt_req");
    idle(); step("halted");
    for (int i = 0; i < 4; i++) begin rnd(0); step("halted_toggle"); end
    idle(); RST = 1; step("halt_reset");
    idle(); step("after_reset");
    ihit = 0;
    for (int i = 0; i < CMAX + 4; i++) step("stall_sat");
    idle(); RST = 1; step("reset2");
    for (int i = 0; i < 600; i++) begin rnd(1); step("random"); end
    @(negedge CLK); #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover got %0d expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
